arbitro_de_funcionalidades: RTL

Parametrised, clocked access arbiter for N user channels competing for shared panel functionalities. Each channel presents a user code (priority), a function code and a request. The block checks per-function permission, grants every channel whose function is uncontended, resolves same-function conflicts by user priority, and holds grants for a bounded time. It sits between the switch/button input stage (buttons already inverted to active-high) and the LED/matrix function decoders.

---
 rtl/arbitro_pkg.sv | 18 +
 rtl/seletor_de_prioridade.sv | 52 +++++
 rtl/arbitro_de_funcionalidades.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the functionality arbiter.
// Holds the neutral function / empty user codes, the FSM state type and the
// fill bit used to build the default permission table (every function open
// to every non-empty user).
package arbitro_pkg;

  localparam int unsigned FUNC_NEUTRO = 0;
  localparam int unsigned USER_NENHUM = 0;

  // Replicated across the whole REQ_LEVEL vector, whatever its width.
  localparam logic REQ_LEVEL_BIT_PADRAO = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } estado_e;

endpackage

// File: rtl/seletor_de_prioridade.sv
// Combinational priority selector for one function code.
// Among the channels that request function FUNC_IDX and are eligible for it
// (non-empty user code, user code >= MIN_USER), returns the one-hot winner:
// highest user code, ties broken towards the lowest channel index.
// Ports:
//   req_i   per-channel request
//   user_i  per-channel user code, channel i at [i*PRIO_W +: PRIO_W]
//   func_i  per-channel function code, same packing
//   win_o   one-hot winner (all zero when nobody is eligible)
module seletor_de_prioridade
  import arbitro_pkg::*;
#(
  parameter int unsigned       N_CH     = 4,
  parameter int unsigned       PRIO_W   = 3,
  parameter int unsigned       FUNC_W   = 3,
  parameter int unsigned       FUNC_IDX = 1,
  parameter logic [PRIO_W-1:0] MIN_USER = '0
) (
  input  logic [N_CH-1:0]        req_i,
  input  logic [N_CH*PRIO_W-1:0] user_i,
  input  logic [N_CH*FUNC_W-1:0] func_i,
  output logic [N_CH-1:0]        win_o
);

  logic [PRIO_W-1:0] user_ch;
  logic [FUNC_W-1:0] func_ch;
  logic [PRIO_W-1:0] melhor;
  logic              achado;

  always_comb begin
    win_o   = '0;
    user_ch = '0;
    func_ch = '0;
    melhor  = '0;
    achado  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      user_ch = user_i[i*PRIO_W +: PRIO_W];
      func_ch = func_i[i*FUNC_W +: FUNC_W];
      if (req_i[i] && (func_ch == FUNC_W'(FUNC_IDX)) &&
          (user_ch != PRIO_W'(USER_NENHUM)) && (user_ch >= MIN_USER)) begin
        // Strictly greater keeps the earlier (lower-index) channel on a tie.
        if (!achado || (user_ch > melhor)) begin
          win_o    = '0;
          win_o[i] = 1'b1;
          melhor   = user_ch;
          achado   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arbitro_de_funcionalidades.sv
// Clocked access arbiter for N_CH user channels sharing panel functionalities.
// In IDLE the inputs are sampled: every function with at least one eligible
// requester grants its highest-priority channel, denied requests are flagged
// for one cycle. Grants are then frozen in HOLD for at most HOLD_CYCLES
// cycles, or until every granted channel drops its request.
// Ports:
//   CLK, RST   clock and synchronous active-high reset
//   req        per-channel request
//   user       per-channel user code (priority), channel i at [i*PRIO_W +: PRIO_W]
//   func       per-channel function code, same packing
//   gnt        registered grant vector
//   act_func   one bit per function code that some granted channel holds
//   denied     one-cycle pulse per channel whose request lacked permission
//   busy       high while grants are held
module arbitro_de_funcionalidades
  import arbitro_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned PRIO_W      = 3,
  parameter int unsigned FUNC_W      = 3,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter logic [(2**FUNC_W)*PRIO_W-1:0] REQ_LEVEL =
    {((2**FUNC_W)*PRIO_W){REQ_LEVEL_BIT_PADRAO}}
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*PRIO_W-1:0] user,
  input  logic [N_CH*FUNC_W-1:0] func,
  output logic [N_CH-1:0]        gnt,
  output logic [2**FUNC_W-1:0]   act_func,
  output logic [N_CH-1:0]        denied,
  output logic                   busy
);

  localparam int unsigned N_FUNC = 2**FUNC_W;
  localparam int unsigned CNT_W  = $clog2(HOLD_CYCLES + 1);
  // Loaded on entry to HOLD: the entry edge itself counts as the first cycle.
  localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(HOLD_CYCLES - 1);

  estado_e           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [N_FUNC-1:0] act_q, act_d;
  logic [N_CH-1:0]   denied_q, denied_d;

  logic [N_CH-1:0]   vence [1:N_FUNC-1];
  logic [N_CH-1:0]   gnt_prox;
  logic [N_FUNC-1:0] act_prox;
  logic [N_CH-1:0]   negado;
  logic [FUNC_W-1:0] func_ch;
  logic [PRIO_W-1:0] user_ch;
  logic [PRIO_W-1:0] nivel;

  // One selector per real function code; code 0 is the neutral "no request".
  for (genvar f = 1; f < N_FUNC; f++) begin : g_seletor
    seletor_de_prioridade #(
      .N_CH    (N_CH),
      .PRIO_W  (PRIO_W),
      .FUNC_W  (FUNC_W),
      .FUNC_IDX(f),
      .MIN_USER(REQ_LEVEL[f*PRIO_W +: PRIO_W])
    ) u_seletor (
      .req_i (req),
      .user_i(user),
      .func_i(func),
      .win_o (vence[f])
    );
  end

  // Candidate grant set, its function map, and the permission check.
  always_comb begin
    gnt_prox = '0;
    act_prox = '0;
    negado   = '0;
    func_ch  = '0;
    user_ch  = '0;
    nivel    = '0;
    for (int f = 1; f < N_FUNC; f++) begin
      gnt_prox = gnt_prox | vence[f];
    end
    for (int i = 0; i < N_CH; i++) begin
      func_ch = func[i*FUNC_W +: FUNC_W];
      user_ch = user[i*PRIO_W +: PRIO_W];
      nivel   = REQ_LEVEL[32'(func_ch)*PRIO_W +: PRIO_W];
      if (req[i] && (func_ch != FUNC_W'(FUNC_NEUTRO)) &&
          ((user_ch == PRIO_W'(USER_NENHUM)) || (user_ch < nivel))) begin
        negado[i] = 1'b1;
      end
      if (gnt_prox[i]) begin
        act_prox[func_ch] = 1'b1;
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    act_d    = act_q;
    denied_d = '0;
    case (estado_q)
      IDLE: begin
        denied_d = negado;
        if (|gnt_prox) begin
          gnt_d    = gnt_prox;
          act_d    = act_prox;
          cnt_d    = CNT_CARGA;
          estado_d = HOLD;
        end
      end
      HOLD: begin
        // Requests are not re-arbitrated here; only expiry or release matter.
        if ((cnt_q == '0) || ((gnt_q & req) == '0)) begin
          estado_d = IDLE;
          gnt_d    = '0;
          act_d    = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        estado_d = IDLE;
        gnt_d    = '0;
        act_d    = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      act_q    <= '0;
      denied_q <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      act_q    <= act_d;
      denied_q <= denied_d;
    end
  end

  assign gnt      = gnt_q;
  assign act_func = act_q;
  assign denied   = denied_q;
  assign busy     = (estado_q == HOLD);

endmodule
